// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first,
// with signed support via magnitude multiply plus final sign fix.
//   state | meaning
//   IDLE  | ready for operands (in_ready=1)
//   RUN   | one shift-add step per cycle, WIDTH cycles total
//   DONE  | result/overflow valid, held until out_ready
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               signed_q, signed_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               overflow_q, overflow_d;

  logic [WIDTH-1:0]   mag1, mag2;
  logic [2*WIDTH-1:0] step_sum, fixed;
  logic [WIDTH:0]     hi_bits;
  logic               fixed_ovf;

  always_comb begin
    mag1 = (in_signed && in1[WIDTH-1]) ? (~in1 + ONE_W) : in1;
    mag2 = (in_signed && in2[WIDTH-1]) ? (~in2 + ONE_W) : in2;
    step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    fixed    = neg_q ? (~step_sum + ONE_2W) : step_sum;
    hi_bits  = fixed[2*WIDTH-1:WIDTH-1];
    // Signed fits iff the top WIDTH+1 bits are a pure sign extension.
    fixed_ovf = signed_q ? ~((&hi_bits) | ~(|hi_bits))
                         : (|fixed[2*WIDTH-1:WIDTH]);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    signed_d   = signed_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, mag1};
          mplier_d = mag2;
          neg_d    = in_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
          signed_d = in_signed;
          cnt_d    = '0;
          acc_d    = '0;
          if (mag1 == '0 || mag2 == '0) begin
            state_d    = DONE;
            result_d   = '0;
            overflow_d = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d    = DONE;
          result_d   = fixed;
          overflow_d = fixed_ovf;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      signed_q   <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      neg_q      <= neg_d;
      signed_q   <= signed_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult: WIDTH=8 instance for the main vectors and a
// WIDTH=16 instance for the wide-latency case.
module tb_seq_mult;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b0;
  logic [7:0]  in1 = '0, in2 = '0;
  logic        in_ready, out_valid, overflow;
  logic [15:0] result;

  logic        in_valid16 = 1'b0, in_signed16 = 1'b0, out_ready16 = 1'b0;
  logic [15:0] in1_16 = '0, in2_16 = '0;
  logic        in_ready16, out_valid16, overflow16;
  logic [31:0] result16;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  seq_mult #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .overflow(overflow)
  );

  seq_mult #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
    .in1(in1_16), .in2(in2_16), .in_signed(in_signed16), .out_valid(out_valid16),
    .out_ready(out_ready16), .result(result16), .overflow(overflow16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, scramble inputs after accept, check latency and result.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [15:0] er, input logic eo,
                       input int elat);
    int lat;
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    in1 = a; in2 = b; in_signed = s; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clock);
    in_valid = 1'b0; in1 = ~a; in2 = a ^ b ^ 8'h5A; in_signed = ~s;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_res"}, 64'(result), 64'(er));
    chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk({tag, "_idle"}, 64'({in_ready, out_valid}), 64'b10);
    chk({tag, "_keep"}, 64'(result), 64'(er));
  endtask

  initial begin
    int lat;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    chk("rst_res", 64'(result), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_ir", 64'(in_ready), 64'd1);

    do_op("u3x8",    8'd3,   8'd8,   1'b0, 16'd24,   1'b0, 9);
    do_op("u20x0",   8'd20,  8'd0,   1'b0, 16'd0,    1'b0, 1);
    do_op("sm3x5",   8'hFD,  8'h05,  1'b1, 16'hFFF1, 1'b0, 9);
    do_op("s80x80",  8'h80,  8'h80,  1'b1, 16'h4000, 1'b1, 9);
    do_op("u255sq",  8'hFF,  8'hFF,  1'b0, 16'hFE01, 1'b1, 9);
    do_op("u25x16",  8'd25,  8'd16,  1'b0, 16'd400,  1'b1, 9);
    do_op("sm1sq",   8'hFF,  8'hFF,  1'b1, 16'h0001, 1'b0, 9);
    do_op("s80x1",   8'h80,  8'h01,  1'b1, 16'hFF80, 1'b0, 9);
    do_op("s0xm5",   8'h00,  8'hFB,  1'b1, 16'h0000, 1'b0, 1);
    do_op("s7xm1",   8'h07,  8'hFF,  1'b1, 16'hFFF9, 1'b0, 9);
    do_op("s9xm16",  8'h09,  8'hF0,  1'b1, 16'hFF70, 1'b1, 9);

    // Backpressure, with in_valid held high through RUN and DONE.
    in1 = 8'd7; in2 = 8'd9; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clock);
    in1 = 8'd100; in2 = 8'd100;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    chk("bp_lat", 64'(lat), 64'd9);
    for (int i = 0; i < 5; i++) begin
      chk("bp_res", 64'(result), 64'd63);
      chk("bp_ir", 64'(in_ready), 64'd0);
      @(negedge clock);
    end
    chk("bp_ov", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp_idle", 64'({in_ready, out_valid}), 64'b10);
    repeat (3) @(negedge clock);
    chk("bp_noq", 64'({in_ready, out_valid}), 64'b10);
    chk("bp_keep", 64'(result), 64'd63);

    // Reset after four RUN steps abandons the operation.
    in1 = 8'd200; in2 = 8'd3; in_signed = 1'b0; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("mr_run", 64'({in_ready, out_valid}), 64'b00);
    reset = 1'b0;
    in_valid = 1'b1; in1 = 8'd5; in2 = 8'd5;
    @(negedge clock);
    chk("mr_idle", 64'({in_ready, out_valid}), 64'b10);
    chk("mr_res", 64'(result), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("mr_noacc", 64'({in_ready, out_valid}), 64'b10);
    do_op("u31x1", 8'd31, 8'd1, 1'b0, 16'd31, 1'b0, 9);

    // Wide instance: latency WIDTH+1 = 17.
    chk("w_rdy", 64'(in_ready16), 64'd1);
    in1_16 = 16'd31; in2_16 = 16'd1; in_signed16 = 1'b0; in_valid16 = 1'b1;
    @(negedge clock);
    in_valid16 = 1'b0; in1_16 = 16'hFFFF; in2_16 = 16'hFFFF;
    lat = 1;
    while (!out_valid16 && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    chk("w_lat", 64'(lat), 64'd17);
    chk("w_res", 64'(result16), 64'd31);
    chk("w_ovf", 64'(overflow16), 64'd0);
    out_ready16 = 1'b1;
    @(negedge clock);
    out_ready16 = 1'b0;
    chk("w_idle", 64'({in_ready16, out_valid16}), 64'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
